con_u_cmp: RTL and testbench

Parametrised successor to the single-operand condition unit in the simple RISC datapath.
- Evaluates a branch condition decoded from IR against the shared bus value, and registers the result on con_out for the control unit.
- Adds two-operand compares: operand A is captured from the bus in one cycle and compared with the bus value in a later cycle, signed or unsigned.
- Adds an operand-tracking state machine and valid/error status outputs.

---
 rtl/con_pkg.sv | 34 +++
 rtl/con_eval.sv | 58 +++++
 rtl/con_u_cmp.sv | 72 +++++++
 tb/tb_con_u_cmp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/con_pkg.sv
// Shared types for the condition unit: condition-code encoding, operand-tracking
// states and the binary-code classifier.
package con_pkg;

   typedef enum logic [3:0] {
      C_NEVER  = 4'd0,
      C_ALWAYS = 4'd1,
      C_EQZ    = 4'd2,
      C_NEZ    = 4'd3,
      C_GEZ    = 4'd4,
      C_LTZ    = 4'd5,
      C_EQ     = 4'd6,
      C_NE     = 4'd7,
      C_LT     = 4'd8,
      C_GE     = 4'd9,
      C_LTU    = 4'd10,
      C_GEU    = 4'd11,
      C_GT     = 4'd12,
      C_LE     = 4'd13,
      C_RSV14  = 4'd14,
      C_RSV15  = 4'd15
   } cond_e;

   typedef enum logic [0:0] {
      EMPTY    = 1'b0,
      A_LOADED = 1'b1
   } state_e;

   // Binary codes are the contiguous block C_EQ..C_LE that compare against operand A.
   function automatic logic is_binary(input cond_e c);
      return (c >= C_EQ) && (c <= C_LE);
   endfunction

endpackage

// File: rtl/con_eval.sv
// Combinational condition evaluator: decodes the condition field and compares
// operand A with the bus, flagging codes that have no defined meaning.
module con_eval
   import con_pkg::*;
#(
   parameter int w  = 32,
   parameter int cw = 4
) (
   input  logic [cw-1:0] code,
   input  logic [w-1:0]  a,
   input  logic [w-1:0]  bus,
   output logic          result,
   output logic          reserved
);

   logic                upper_set;
   logic signed [w-1:0] sa;
   logic signed [w-1:0] sb;
   cond_e               c;

   // Any set bit above the 4-bit code space lands in the reserved range.
   if (cw > 4) begin : g_upper
      assign upper_set = |code[cw-1:4];
   end else begin : g_no_upper
      assign upper_set = 1'b0;
   end

   assign c  = cond_e'(code[3:0]);
   assign sa = $signed(a);
   assign sb = $signed(bus);

   always_comb begin
      result   = 1'b0;
      reserved = 1'b0;
      if (upper_set) begin
         reserved = 1'b1;
      end else begin
         case (c)
            C_NEVER:  result = 1'b0;
            C_ALWAYS: result = 1'b1;
            C_EQZ:    result = (bus == '0);
            C_NEZ:    result = (bus != '0);
            C_GEZ:    result = ~bus[w-1];
            C_LTZ:    result = bus[w-1];
            C_EQ:     result = (a == bus);
            C_NE:     result = (a != bus);
            C_LT:     result = (sa < sb);
            C_GE:     result = (sa >= sb);
            C_LTU:    result = (a < bus);
            C_GEU:    result = (a >= bus);
            C_GT:     result = (sa > sb);
            C_LE:     result = (sa <= sb);
            default:  reserved = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/con_u_cmp.sv
// Condition unit with a captured compare operand: holds operand A, tracks whether
// it is loaded, and registers the condition result with valid and error status.
module con_u_cmp
   import con_pkg::*;
#(
   parameter int w     = 32,
   parameter int cw    = 4,
   parameter int c_lsb = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [w-1:0] bus,
   input  logic [w-1:0] IR,
   input  logic         con_lda,
   input  logic         con_in,
   output logic         con_out,
   output logic         con_valid,
   output logic         a_valid,
   output logic         con_err
);

   logic [cw-1:0] code;
   logic [w-1:0]  a_reg;
   state_e        state;
   logic          eval_result;
   logic          eval_reserved;
   logic          code_binary;
   logic          eval_err;
   logic          unused_ir;

   assign code      = IR[c_lsb +: cw];
   assign unused_ir = ^IR;

   con_eval #(
      .w  (w),
      .cw (cw)
   ) u_eval (
      .code     (code),
      .a        (a_reg),
      .bus      (bus),
      .result   (eval_result),
      .reserved (eval_reserved)
   );

   assign code_binary = !eval_reserved && is_binary(cond_e'(code[3:0]));
   assign eval_err    = eval_reserved || (code_binary && (state == EMPTY));
   assign a_valid     = (state == A_LOADED);

   // A load in the same cycle as a consuming compare wins: the compare used the old A.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         con_out   <= 1'b0;
         con_valid <= 1'b0;
         con_err   <= 1'b0;
         a_reg     <= '0;
         state     <= EMPTY;
      end else begin
         con_valid <= con_in;
         if (con_in) begin
            con_out <= eval_err ? 1'b0 : eval_result;
            con_err <= eval_err;
         end
         if (con_lda) begin
            a_reg <= bus;
            state <= A_LOADED;
         end else if (con_in && code_binary && (state == A_LOADED)) begin
            state <= EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_con_u_cmp.sv
// Scoreboard bench for con_u_cmp: a driver pushes model predictions per cycle and
// an independent monitor pops and compares them against the registered outputs.
module tb_con_u_cmp;

   localparam int W   = 32;
   localparam int CW  = 4;
   localparam int LSB = 0;

   typedef struct {
      logic valid;
      logic out;
      logic err;
      logic aval;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] bus;
   logic [W-1:0] IR;
   logic         con_lda;
   logic         con_in;
   logic         con_out;
   logic         con_valid;
   logic         a_valid;
   logic         con_err;

   int total;
   int bad;

   exp_t exp_q[$];

   logic [W-1:0] m_a;
   bit           m_loaded;
   bit           m_out;
   bit           m_err;

   con_u_cmp #(
      .w     (W),
      .cw    (CW),
      .c_lsb (LSB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .IR        (IR),
      .con_lda   (con_lda),
      .con_in    (con_in),
      .con_out   (con_out),
      .con_valid (con_valid),
      .a_valid   (a_valid),
      .con_err   (con_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference condition evaluation using plain integer arithmetic on 64-bit values.
   function automatic bit ref_eval(input int code, input logic [W-1:0] a, input logic [W-1:0] b);
      longint ua, ub, sa, sb;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = (ua >= 64'sd2147483648) ? ua - 64'sd4294967296 : ua;
      sb = (ub >= 64'sd2147483648) ? ub - 64'sd4294967296 : ub;
      case (code)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return ub == 0;
         3:       return ub != 0;
         4:       return sb >= 0;
         5:       return sb < 0;
         6:       return sa == sb;
         7:       return sa != sb;
         8:       return sa < sb;
         9:       return sa >= sb;
         10:      return ua < ub;
         11:      return ua >= ub;
         12:      return sa > sb;
         13:      return sa <= sb;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_a      = '0;
      m_loaded = 1'b0;
      m_out    = 1'b0;
      m_err    = 1'b0;
   endtask

   task automatic apply_stimulus(input bit lda, input bit cin, input int code,
                                 input logic [W-1:0] busv, input bit bus_x);
      exp_t      e;
      bit        binary;
      logic [W-1:0] ir_v;
      @(negedge clk);
      ir_v    = W'($urandom());
      ir_v[LSB +: CW] = CW'(code);
      IR      = ir_v;
      con_lda = lda;
      con_in  = cin;
      bus     = (bus_x && !lda && !cin) ? 'x : busv;
      binary  = (code >= 6) && (code <= 13);
      if (cin) begin
         if (code >= 14 || (binary && !m_loaded)) begin
            m_out = 1'b0;
            m_err = 1'b1;
         end else begin
            m_out = ref_eval(code, m_a, busv);
            m_err = 1'b0;
            if (binary) m_loaded = 1'b0;
         end
      end
      if (lda) begin
         m_a      = busv;
         m_loaded = 1'b1;
      end
      e.valid = cin;
      e.out   = m_out;
      e.err   = m_err;
      e.aval  = m_loaded;
      exp_q.push_back(e);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      con_lda = 1'b0;
      con_in  = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_output("rst_con_out", con_out, 1'b0);
      check_output("rst_con_valid", con_valid, 1'b0);
      check_output("rst_con_err", con_err, 1'b0);
      check_output("rst_a_valid", a_valid, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [W-1:0] pick_bus();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4, 5:    return W'($urandom_range(0, 7));
         default: return W'($urandom());
      endcase
   endfunction

   // Monitor: one prediction per clocked cycle outside reset.
   initial begin
      exp_t r;
      forever begin
         @(posedge clk);
         #1;
         if (rst) continue;
         if (exp_q.size() == 0) begin
            check_output("spurious_con_valid", con_valid, 1'b0);
         end else begin
            r = exp_q.pop_front();
            check_output("con_valid", con_valid, r.valid);
            check_output("con_out", con_out, r.out);
            check_output("con_err", con_err, r.err);
            check_output("a_valid", a_valid, r.aval);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      con_lda = 1'b0;
      con_in  = 1'b0;
      bus     = '0;
      IR      = '0;
      model_reset();
      #12;
      check_output("init_con_out", con_out, 1'b0);
      check_output("init_con_valid", con_valid, 1'b0);
      check_output("init_con_err", con_err, 1'b0);
      check_output("init_a_valid", a_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int c = 0; c < 6; c++) apply_stimulus(0, 1, c, 32'h0000_0000, 0);
      for (int c = 0; c < 6; c++) apply_stimulus(0, 1, c, 32'hFFFF_FFFF, 0);

      apply_stimulus(1, 0, 0, 32'hFFFF_FFFF, 0);
      apply_stimulus(0, 1, 8, 32'd1, 0);
      apply_stimulus(1, 0, 0, 32'hFFFF_FFFF, 0);
      apply_stimulus(0, 1, 10, 32'd1, 0);

      apply_stimulus(1, 0, 0, 32'd5, 0);
      apply_stimulus(0, 1, 6, 32'd5, 0);
      apply_stimulus(0, 1, 6, 32'd5, 0);

      apply_stimulus(1, 0, 0, 32'd7, 0);
      apply_stimulus(0, 1, 2, 32'd0, 0);
      apply_stimulus(0, 1, 12, 32'd3, 0);

      apply_stimulus(1, 0, 0, 32'd2, 0);
      apply_stimulus(1, 1, 13, 32'd9, 0);
      apply_stimulus(0, 1, 6, 32'd9, 0);

      apply_stimulus(0, 1, 14, 32'd0, 0);
      apply_stimulus(1, 0, 0, 32'd4, 0);
      mid_reset();
      apply_stimulus(0, 1, 6, 32'd4, 0);

      for (int i = 0; i < 400; i++) begin
         bit lda, cin;
         lda = ($urandom_range(0, 3) == 0);
         cin = ($urandom_range(0, 1) == 1);
         apply_stimulus(lda, cin, $urandom_range(0, 15), pick_bus(), $urandom_range(0, 1) == 1);
      end

      repeat (3) apply_stimulus(0, 0, 0, 32'd0, 0);
      @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
